// File: rtl/counter_seq_pkg.sv
// Shared state encoding and mode constants for the counter sequencer.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/counter_core.sv
// Counter datapath: synchronous clear, increment on enable, modulo 2^WIDTH.
module counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_sequencer.sv
// Start/stop/pause sequencer around counter_core with one-shot and periodic modes.
// Optional tick prescaler is enabled by defining COUNTER_SEQ_PRESCALE_EN.
//
// state | meaning
// IDLE  | waiting for start, count cleared
// RUN   | counting on each tick
// HOLD  | paused, count and prescaler frozen
// DONE  | one-shot finished, count holds at limit
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      limit,
`ifdef COUNTER_SEQ_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap
);

  state_t           state;
  logic [WIDTH-1:0] limit_q;
  logic             tick;
  logic             at_limit;
  logic             core_clear;
  logic             core_en;
  logic             accept;

  assign at_limit = (count == limit_q);
  assign accept   = !stop && start && (state == IDLE || state == DONE);

`ifdef COUNTER_SEQ_PRESCALE_EN
  logic [PRESCALE_W-1:0] presc;

  // Tick on phase 0, so the first tick lands one clock after start acceptance.
  assign tick = (presc == '0);

  always_ff @(posedge clk) begin
    if (rst || stop || accept) begin
      presc <= '0;
    end else if (state == RUN && !pause) begin
      presc <= (presc == prescale) ? '0 : presc + PRESCALE_W'(1);
    end
  end
`else
  logic [PRESCALE_W-1:0] unused_presc;
  assign unused_presc = '0;
  assign tick         = 1'b1;
`endif

  always_comb begin
    core_clear = 1'b0;
    core_en    = 1'b0;
    if (stop || accept) begin
      core_clear = 1'b1;
    end else if (state == RUN && !pause && tick) begin
      if (!at_limit)                   core_en    = 1'b1;
      else if (mode == MODE_PERIODIC)  core_clear = 1'b1;
    end
  end

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst    (rst),
    .clear  (core_clear),
    .enable (core_en),
    .count  (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      limit_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      if (stop) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              state   <= RUN;
              limit_q <= limit;
              busy    <= 1'b1;
            end
          end
          RUN: begin
            if (pause) begin
              state <= HOLD;
            end else if (tick && at_limit) begin
              if (mode == MODE_PERIODIC) begin
                wrap <= 1'b1;
              end else begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
              end
            end
          end
          HOLD: begin
            if (!pause) state <= RUN;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed table-driven bench for counter_sequencer (prescale test under COUNTER_SEQ_PRESCALE_EN).
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, stop, pause, mode;
  logic [3:0] limit;
  logic [3:0] count;
  logic       busy, done, wrap;
`ifdef COUNTER_SEQ_PRESCALE_EN
  logic [3:0] prescale;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(4), .PRESCALE_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .limit    (limit),
`ifdef COUNTER_SEQ_PRESCALE_EN
    .prescale (prescale),
`endif
    .count    (count),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  typedef struct {
    logic       r, s, p, pa, m;
    logic [3:0] lim;
    logic [3:0] e_count;
    logic       e_busy, e_done, e_wrap;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic s, logic p, logic pa, logic m, logic [3:0] lim,
                              logic [3:0] c, logic b, logic d, logic w);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.pa = pa; v.m = m; v.lim = lim;
    v.e_count = c; v.e_busy = b; v.e_done = d; v.e_wrap = w;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Inputs change just after a rising edge; outputs are sampled 1ns after the next one.
  task automatic step(input logic r, input logic s, input logic p, input logic pa,
                      input logic m, input logic [3:0] lim);
    rst = r; start = s; stop = p; pause = pa; mode = m; limit = lim;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string nm, input int c, input int b, input int d, input int w);
    check({nm, ".count"}, int'(count), c);
    check({nm, ".busy"},  int'(busy),  b);
    check({nm, ".done"},  int'(done),  d);
    check({nm, ".wrap"},  int'(wrap),  w);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; limit = '0;
`ifdef COUNTER_SEQ_PRESCALE_EN
    prescale = '0;
`endif

    //                 r  s  p  pa m  lim   cnt b  d  w
    vecs.push_back(mk(1, 1, 0, 0, 0, 4'd5, 0,  0, 0, 0));  // reset with start
    vecs.push_back(mk(1, 1, 0, 0, 0, 4'd5, 0,  0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'd5, 0,  1, 0, 0));  // one-shot limit 5
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 1,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 2,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 3,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 4,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 5,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 5,  0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 5,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 5,  0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'd3, 0,  1, 0, 0));  // periodic limit 3 from DONE
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'd0, 1,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'd0, 2,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'd0, 3,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'd0, 0,  1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'd0, 1,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'd0, 2,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'd0, 3,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'd0, 0,  1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'd0, 1,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 2,  1, 0, 0));  // mode switched live to one-shot
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 3,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 3,  0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 4'd0, 0,  0, 0, 0));  // stop in DONE
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'd4, 0,  1, 0, 0));  // start, limit 4
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'd2, 1,  1, 0, 0));  // restart ignored
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd2, 2,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd2, 3,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd2, 4,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd2, 4,  0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 4'd0, 0,  1, 0, 0));  // limit 0 one-shot
    vecs.push_back(mk(0, 0, 0, 0, 0, 4'd0, 0,  0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 4'd0, 0,  1, 0, 0));  // limit 0 periodic
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'd0, 0,  1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4'd0, 0,  1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 1, 4'd0, 0,  0, 0, 0));  // reset mid-run

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].s, vecs[i].p, vecs[i].pa, vecs[i].m, vecs[i].lim);
      check_all($sformatf("vec%0d", i), int'(vecs[i].e_count), int'(vecs[i].e_busy),
                int'(vecs[i].e_done), int'(vecs[i].e_wrap));
    end

    // pause at 4 for three cycles, then stop together with pause
    step(0, 1, 0, 0, 0, 4'd9);
    repeat (4) step(0, 0, 0, 0, 0, 4'd9);
    check("pause.pre", int'(count), 4);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 0, 4'd9);
      check_all($sformatf("hold%0d", i), 4, 1, 0, 0);
    end
    step(0, 0, 1, 1, 0, 4'd9);
    check_all("stop_pause", 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 4'd9);
    check_all("idle_after_stop", 0, 0, 0, 0);

    // pause release: the return cycle does not count
    step(0, 1, 0, 0, 0, 4'd9);
    step(0, 0, 0, 0, 0, 4'd9);
    step(0, 0, 0, 0, 0, 4'd9);
    step(0, 0, 0, 1, 0, 4'd9);
    check("rel.hold", int'(count), 2);
    step(0, 0, 0, 0, 0, 4'd9);
    check("rel.return", int'(count), 2);
    step(0, 0, 0, 0, 0, 4'd9);
    check("rel.resume", int'(count), 3);
    step(0, 0, 1, 0, 0, 4'd0);
    check_all("rel.stop", 0, 0, 0, 0);

    // full-range periodic wrap at limit 15
    step(0, 1, 0, 0, 1, 4'd15);
    for (int i = 1; i <= 15; i++) begin
      step(0, 0, 0, 0, 1, 4'd0);
      check($sformatf("max.count%0d", i), int'(count), i);
      check($sformatf("max.wrap%0d", i), int'(wrap), 0);
    end
    step(0, 0, 0, 0, 1, 4'd0);
    check_all("max.wrap", 0, 1, 0, 1);
    step(0, 0, 1, 0, 0, 4'd0);

    // reset on the cycle that would otherwise complete
    step(0, 1, 0, 0, 0, 4'd2);
    step(0, 0, 0, 0, 0, 4'd2);
    step(0, 0, 0, 0, 0, 4'd2);
    check("rst_term.pre", int'(count), 2);
    step(1, 0, 0, 0, 0, 4'd2);
    check_all("rst_term", 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 4'd2);
    check_all("rst_term.after", 0, 0, 0, 0);

`ifdef COUNTER_SEQ_PRESCALE_EN
    prescale = 4'd2;
    step(0, 1, 0, 0, 0, 4'd2);
    check_all("ps.accept", 0, 1, 0, 0);
    for (int c = 1; c <= 8; c++) begin
      step(0, 0, 0, 0, 0, 4'd2);
      check($sformatf("ps.count%0d", c), int'(count), (c >= 4) ? 2 : 1);
      check($sformatf("ps.done%0d", c), int'(done), (c == 7) ? 1 : 0);
    end
    prescale = 4'd0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
